// File: rtl/sfp_ctrl.sv
// sfp_ctrl: sequences partial-sum accumulation through the SFP lanes.
// Each OFIFO row popped in ACC is paired with a psum-memory read of the same
// pixel. One cycle later the SFP beat is launched (sfp_valid/first/relu). One
// cycle after that the result is written back to the same address. The
// controller walks num_pix pixels per pass for num_pass passes, then drains
// the two-deep pipeline and pulses done.
//
// Optional build macro: SFP_CTRL_RELU_EN. When it is defined, sfp_relu marks
// beats of the last pass. When it is undefined, sfp_relu is tied to 0.
//
// Parameters: col (SFP lanes), psum_bw (psum width per lane),
//             num_pix (pixels per pass, 3..2^addr_bw), addr_bw (psum address width)
// Ports:
//   clk, reset (async, active low)
//   start, num_pass[3:0]          job request; num_pass 0 is treated as 1
//   ofifo_valid / ofifo_rd        OFIFO row handshake (ofifo_rd is combinational)
//   pmem_rd, pmem_rd_addr         psum read for the beat issued this cycle (combinational)
//   sfp_valid, sfp_first, sfp_relu  SFP beat controls, one cycle after issue
//   pmem_wr, pmem_wr_addr         write-back, two cycles after issue
//   busy, done                    job status; done is a one-cycle pulse
module sfp_ctrl #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned num_pix = 16,
    parameter int unsigned addr_bw = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         num_pass,
    input  logic               ofifo_valid,
    output logic               ofifo_rd,
    output logic               pmem_rd,
    output logic [addr_bw-1:0] pmem_rd_addr,
    output logic               sfp_valid,
    output logic               sfp_first,
    output logic               sfp_relu,
    output logic               pmem_wr,
    output logic [addr_bw-1:0] pmem_wr_addr,
    output logic               busy,
    output logic               done
);

    localparam logic [addr_bw-1:0] pix_last = addr_bw'(num_pix - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [addr_bw-1:0] pix_cnt, pix_cnt_nxt;
    logic [3:0]         pass_cnt, pass_cnt_nxt;
    logic [3:0]         last_pass, last_pass_nxt;
    logic               drain_cnt, drain_cnt_nxt;
    logic               busy_nxt, done_nxt;
    logic               issue;
    logic [addr_bw-1:0] pipe_addr;

    // Lane count and psum width size the datapath, not this sequencer.
    logic unused_cfg;
    assign unused_cfg = ^{col, psum_bw};

    // FSM and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            pass_cnt  <= '0;
            last_pass <= '0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pix_cnt   <= pix_cnt_nxt;
            pass_cnt  <= pass_cnt_nxt;
            last_pass <= last_pass_nxt;
            drain_cnt <= drain_cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next state, counters and issue decision.
    always_comb begin
        state_nxt     = state;
        pix_cnt_nxt   = pix_cnt;
        pass_cnt_nxt  = pass_cnt;
        last_pass_nxt = last_pass;
        drain_cnt_nxt = drain_cnt;
        issue         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = ACC;
                    pix_cnt_nxt   = '0;
                    pass_cnt_nxt  = '0;
                    last_pass_nxt = (num_pass == 4'd0) ? 4'd0 : num_pass - 4'd1;
                end
            end
            ACC: begin
                if (ofifo_valid) begin
                    issue = 1'b1;
                    if (pix_cnt == pix_last) begin
                        // Pass boundary: wrap the pixel and move on without a bubble.
                        pix_cnt_nxt = '0;
                        if (pass_cnt == last_pass) begin
                            state_nxt     = DRAIN;
                            drain_cnt_nxt = 1'b0;
                        end else begin
                            pass_cnt_nxt = pass_cnt + 4'd1;
                        end
                    end else begin
                        pix_cnt_nxt = pix_cnt + addr_bw'(1);
                    end
                end
            end
            DRAIN: begin
                // Two cycles let the final beat leave the SFP and write back.
                if (drain_cnt) begin
                    state_nxt = DONE;
                end else begin
                    drain_cnt_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    // The OFIFO pop and the psum read happen in the issue cycle itself.
    assign ofifo_rd     = issue;
    assign pmem_rd      = issue;
    assign pmem_rd_addr = pix_cnt;

    // Issue -> SFP beat -> write-back pipeline. It never stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sfp_valid    <= 1'b0;
            sfp_first    <= 1'b0;
            pipe_addr    <= '0;
            pmem_wr      <= 1'b0;
            pmem_wr_addr <= '0;
        end else begin
            sfp_valid    <= issue;
            sfp_first    <= issue && (pass_cnt == 4'd0);
            pipe_addr    <= issue ? pix_cnt : '0;
            pmem_wr      <= sfp_valid;
            pmem_wr_addr <= pipe_addr;
        end
    end

`ifdef SFP_CTRL_RELU_EN
    // ReLU is applied only on the final accumulation pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sfp_relu <= 1'b0;
        end else begin
            sfp_relu <= issue && (pass_cnt == last_pass);
        end
    end
`else
    assign sfp_relu = 1'b0;
`endif

endmodule
